// File: rtl/mem_access.sv
// mem_access: MEM stage of the RISC-V pipeline.
// Runs loads and stores over a shared 8-bit memory bus, one byte per granted
// cycle. While an access is in progress it holds upstream stages with
// stall_req. Non-memory instructions pass straight through to writeback.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global ready; low freezes all state
//   we_in/waddr_in/wdata_in   register-write info from EX
//   ma_we, ma_re        store / load request (store wins)
//   ma_width            [1:0] 00 byte, 01 half, 1x word; [2] zero-extend load
//   ma_addr, ma_wdata   byte address, store data
//   mem_gnt, mem_din    bus grant, read byte (valid cycle after address)
//   mem_req, mem_a, mem_wr, mem_dout   bus request, address, strobe, write byte
//   we, waddr, wdata    to MEM/WB
//   stall_req           hold all upstream stages
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        we_in,
    input  logic [4:0]  waddr_in,
    input  logic [31:0] wdata_in,
    input  logic        ma_we,
    input  logic        ma_re,
    input  logic [2:0]  ma_width,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_wdata,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic        mem_req,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        stall_req
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [2:0]  r_cnt;
    logic        r_pend;
    logic [1:0]  r_pidx;
    logic [31:0] r_buf;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [2:0]  r_width;
    logic        r_store;

    logic        w_mem_op;
    logic [2:0]  w_n;
    logic        w_issue;
    logic [7:0]  w_store_byte;
    logic [31:0] w_load_val;

    assign w_mem_op = ma_we | ma_re;

    always_comb begin
        unique case (r_width[1:0])
            2'b00:   w_n = 3'd1;
            2'b01:   w_n = 3'd2;
            default: w_n = 3'd4;
        endcase
    end

    // A byte goes out only when granted and bytes remain.
    assign w_issue      = (r_state == StXfer) && mem_gnt && (r_cnt < w_n);
    assign w_store_byte = r_data[{r_cnt[1:0], 3'b000} +: 8];

    // Sign- or zero-extension of the assembled load value.
    always_comb begin
        unique case (r_width[1:0])
            2'b00:   w_load_val = {{24{~r_width[2] & r_buf[7]}}, r_buf[7:0]};
            2'b01:   w_load_val = {{16{~r_width[2] & r_buf[15]}}, r_buf[15:0]};
            default: w_load_val = r_buf;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_mem_op) w_state_d = StXfer;
            end
            StXfer: begin
                if (r_store) begin
                    if (w_issue && (r_cnt + 3'd1 == w_n)) w_state_d = StDone;
                end else begin
                    // Last byte is issued; leave once its read data is captured.
                    if (r_pend && (r_cnt == w_n)) w_state_d = StDone;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
            r_pend  <= 1'b0;
            r_pidx  <= 2'd0;
            r_buf   <= 32'd0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_width <= 3'd0;
            r_store <= 1'b0;
        end else if (rdy) begin
            r_state <= w_state_d;
            unique case (r_state)
                StIdle: begin
                    if (w_mem_op) begin
                        r_addr  <= ma_addr;
                        r_data  <= ma_wdata;
                        r_width <= ma_width;
                        r_store <= ma_we;
                        r_cnt   <= 3'd0;
                        r_pend  <= 1'b0;
                    end
                end
                StXfer: begin
                    // Capture is independent of grant; grant loss only pauses issue.
                    if (r_pend) r_buf[{r_pidx, 3'b000} +: 8] <= mem_din;
                    r_pend <= w_issue & ~r_store;
                    if (w_issue) begin
                        r_cnt  <= r_cnt + 3'd1;
                        r_pidx <= r_cnt[1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_a     = 32'd0;
        mem_wr    = 1'b0;
        mem_dout  = 8'd0;
        we        = 1'b0;
        waddr     = 5'd0;
        wdata     = 32'd0;
        stall_req = 1'b0;
        if (!rst) begin
            unique case (r_state)
                StIdle: begin
                    if (w_mem_op) begin
                        stall_req = 1'b1;
                    end else begin
                        we    = we_in;
                        waddr = waddr_in;
                        wdata = wdata_in;
                    end
                end
                StXfer: begin
                    mem_req   = 1'b1;
                    stall_req = 1'b1;
                    if (w_issue) begin
                        mem_a    = r_addr + {29'd0, r_cnt};
                        mem_wr   = r_store & rdy;
                        mem_dout = r_store ? w_store_byte : 8'd0;
                    end
                end
                default: begin
                    we    = we_in;
                    waddr = waddr_in;
                    wdata = r_store ? wdata_in : w_load_val;
                end
            endcase
        end
    end

endmodule
